// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_pkg
// Purpose  : Shared sizing, types and constants for the integer register file
//            and its pending-write scoreboard.
// Contents : XLEN / NREGS / AW / CNT_W sizing, reg_addr_t, reg_data_t,
//            sb_cnt_t typedefs, REG_ZERO, CNT_MAX and CNT_ONE constants.
// Revision : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);
    // Up to 2**CNT_W-1 writes to one register may be in flight at once.
    localparam int CNT_W = 2;

    typedef logic [AW-1:0]    reg_addr_t;
    typedef logic [XLEN-1:0]  reg_data_t;
    typedef logic [CNT_W-1:0] sb_cnt_t;

    localparam reg_addr_t REG_ZERO = '0;
    localparam sb_cnt_t   CNT_MAX  = '1;
    localparam sb_cnt_t   CNT_ONE  = sb_cnt_t'(1);

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_sb_counter.sv
`default_nettype none
// ============================================================================
// Module   : rf_sb_counter
// Purpose  : Pending-write counter for one architectural register.
//            Increments on reservation, decrements on write-back, and is
//            cleared by flush. A simultaneous inc and dec cancels out. The
//            count saturates at both ends rather than wrapping.
// Ports    : clk, rst_n     - clock, asynchronous active-low reset
//            i_inc          - reservation of this register accepted
//            i_dec          - write-back to this register
//            i_clr          - flush; overrides i_inc and i_dec
//            o_cnt          - current pending-write count
//            o_err_evt      - write-back arrived with nothing pending
// Revision : 1.0 - initial release
// ============================================================================
module rf_sb_counter
    import rf_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_inc,
    input  logic    i_dec,
    input  logic    i_clr,
    output sb_cnt_t o_cnt,
    output logic    o_err_evt
);

    sb_cnt_t r_cnt;
    logic    w_zero;
    logic    w_max;

    assign w_zero = (r_cnt == '0);
    assign w_max  = (r_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec) begin
            if (!w_max) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end else if (i_dec && !i_inc) begin
            if (!w_zero) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

    // An orphan write-back is flagged even during a flush; the flush only
    // drops bookkeeping, it does not excuse an unexpected write.
    assign o_err_evt = i_dec && !i_inc && w_zero;
    assign o_cnt     = r_cnt;

endmodule : rf_sb_counter
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_scoreboard
// Purpose  : Integer register file with a per-register pending-write
//            scoreboard. Decode reserves rd at issue, the WB write port
//            retires the reservation and updates the array. Generates the
//            decode stall for RAW hazards and for a saturated counter.
// Ports    : clk, rst_n                    - clock, async active-low reset
//            i_wb_wr_reg_en/addr/data      - WB write port
//            i_rs1_addr, i_rs2_addr        - ID source addresses
//            i_rs1_used, i_rs2_used        - ID instruction reads rsN
//            i_rsv_en, i_rsv_addr          - ID issues a write to rd
//            i_flush                       - drop all reservations
//            o_rs1_data, o_rs2_data        - combinational read data
//            o_stall                       - hold ID this cycle
//            o_sb_err                      - sticky orphan write-back flag
// Config   : RF_BYPASS_EN - when defined, a WB write retiring the last
//            pending write of rsN is forwarded to o_rsN_data in the same
//            cycle and does not stall. Undefined: ID waits one cycle more.
// Revision : 1.0 - initial release
// ============================================================================
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_wb_wr_reg_en,
    input  reg_addr_t i_wb_wr_reg_addr,
    input  reg_data_t i_wb_wr_reg_data,
    input  reg_addr_t i_rs1_addr,
    input  reg_addr_t i_rs2_addr,
    input  logic      i_rs1_used,
    input  logic      i_rs2_used,
    input  logic      i_rsv_en,
    input  reg_addr_t i_rsv_addr,
    input  logic      i_flush,
    output reg_data_t o_rs1_data,
    output reg_data_t o_rs2_data,
    output logic      o_stall,
    output logic      o_sb_err
);

    // x0 has neither storage nor a counter; both arrays start at index 1.
    reg_data_t        w_regs [1:NREGS-1];
    sb_cnt_t          w_cnt  [1:NREGS-1];
    logic [NREGS-1:1] w_err_evt;

    reg_data_t w_rd1;
    reg_data_t w_rd2;
    sb_cnt_t   w_cnt_rs1;
    sb_cnt_t   w_cnt_rs2;
    sb_cnt_t   w_cnt_rsv;
    logic      w_byp1;
    logic      w_byp2;
    logic      w_haz1;
    logic      w_haz2;
    logic      w_full;
    logic      w_stall;
    logic      r_sb_err;

    // ------------------------------------------------------------------
    // Per-register storage and scoreboard counter
    // ------------------------------------------------------------------
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
        reg_data_t r_q;
        logic      w_hit_wb;
        logic      w_hit_rsv;

        assign w_hit_wb  = i_wb_wr_reg_en && (i_wb_wr_reg_addr == reg_addr_t'(gi));
        // A stalled instruction does not issue, so its reservation is dropped.
        assign w_hit_rsv = i_rsv_en && !w_stall && (i_rsv_addr == reg_addr_t'(gi));

        // The array is written even when the write is an orphan or a flush
        // is in progress; only the bookkeeping is affected by those cases.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (w_hit_wb) begin
                r_q <= i_wb_wr_reg_data;
            end
        end

        assign w_regs[gi] = r_q;

        rf_sb_counter u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_inc     (w_hit_rsv),
            .i_dec     (w_hit_wb),
            .i_clr     (i_flush),
            .o_cnt     (w_cnt[gi]),
            .o_err_evt (w_err_evt[gi])
        );
    end : g_reg

    // ------------------------------------------------------------------
    // Read muxes; address 0 falls through to the zero defaults
    // ------------------------------------------------------------------
    always_comb begin
        w_rd1     = '0;
        w_rd2     = '0;
        w_cnt_rs1 = '0;
        w_cnt_rs2 = '0;
        w_cnt_rsv = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (i_rs1_addr == reg_addr_t'(i)) begin
                w_rd1     = w_regs[i];
                w_cnt_rs1 = w_cnt[i];
            end
            if (i_rs2_addr == reg_addr_t'(i)) begin
                w_rd2     = w_regs[i];
                w_cnt_rs2 = w_cnt[i];
            end
            if (i_rsv_addr == reg_addr_t'(i)) begin
                w_cnt_rsv = w_cnt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Write-back forwarding. Only the last outstanding write may be
    // forwarded: with more in flight the value is not yet final.
    // ------------------------------------------------------------------
`ifdef RF_BYPASS_EN
    assign w_byp1 = i_wb_wr_reg_en && (i_wb_wr_reg_addr == i_rs1_addr) &&
                    (i_rs1_addr != REG_ZERO) && (w_cnt_rs1 == CNT_ONE);
    assign w_byp2 = i_wb_wr_reg_en && (i_wb_wr_reg_addr == i_rs2_addr) &&
                    (i_rs2_addr != REG_ZERO) && (w_cnt_rs2 == CNT_ONE);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    assign o_rs1_data = w_byp1 ? i_wb_wr_reg_data : w_rd1;
    assign o_rs2_data = w_byp2 ? i_wb_wr_reg_data : w_rd2;

    // ------------------------------------------------------------------
    // Stall: RAW on either source, or rd counter already saturated.
    // The full check ignores a same-cycle WB to rd to keep the path short;
    // the stall simply releases one cycle later.
    // ------------------------------------------------------------------
    assign w_haz1  = i_rs1_used && (i_rs1_addr != REG_ZERO) && (w_cnt_rs1 != '0) && !w_byp1;
    assign w_haz2  = i_rs2_used && (i_rs2_addr != REG_ZERO) && (w_cnt_rs2 != '0) && !w_byp2;
    assign w_full  = i_rsv_en && (i_rsv_addr != REG_ZERO) && (w_cnt_rsv == CNT_MAX);
    assign w_stall = w_haz1 || w_haz2 || w_full;
    assign o_stall = w_stall;

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb_err <= 1'b0;
        end else if (|w_err_evt) begin
            r_sb_err <= 1'b1;
        end
    end

    assign o_sb_err = r_sb_err;

endmodule : rf_scoreboard
`default_nettype wire

// File: tb/tb_rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_scoreboard
// Purpose  : Self-checking bench for rf_scoreboard. A per-cycle vector table
//            covers x0 handling, RAW stall/forwarding, counter saturation,
//            simultaneous reserve+retire, flush and the sticky error flag.
//            Hand-written sequences cover reset at start and mid-write.
//            Expected values follow RF_BYPASS_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_scoreboard;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        i_wb_wr_reg_en;
    logic [4:0]  i_wb_wr_reg_addr;
    logic [31:0] i_wb_wr_reg_data;
    logic [4:0]  i_rs1_addr;
    logic [4:0]  i_rs2_addr;
    logic        i_rs1_used;
    logic        i_rs2_used;
    logic        i_rsv_en;
    logic [4:0]  i_rsv_addr;
    logic        i_flush;
    logic [31:0] o_rs1_data;
    logic [31:0] o_rs2_data;
    logic        o_stall;
    logic        o_sb_err;

    int n_total = 0;
    int n_pass  = 0;

    rf_scoreboard dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_wb_wr_reg_en   (i_wb_wr_reg_en),
        .i_wb_wr_reg_addr (i_wb_wr_reg_addr),
        .i_wb_wr_reg_data (i_wb_wr_reg_data),
        .i_rs1_addr       (i_rs1_addr),
        .i_rs2_addr       (i_rs2_addr),
        .i_rs1_used       (i_rs1_used),
        .i_rs2_used       (i_rs2_used),
        .i_rsv_en         (i_rsv_en),
        .i_rsv_addr       (i_rsv_addr),
        .i_flush          (i_flush),
        .o_rs1_data       (o_rs1_data),
        .o_rs2_data       (o_rs2_data),
        .o_stall          (o_stall),
        .o_sb_err         (o_sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic        rsv_en;
        logic [4:0]  rsv_addr;
        logic        flush;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        es;
        logic        ee;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm,
                                input logic wb_en, input logic [4:0] wb_addr, input logic [31:0] wb_data,
                                input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                                input logic rsv_en, input logic [4:0] rsv_addr, input logic flush,
                                input logic [31:0] e1, input logic [31:0] e2, input logic es, input logic ee);
        vec_t v;
        v.name = nm; v.wb_en = wb_en; v.wb_addr = wb_addr; v.wb_data = wb_data;
        v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rsv_en = rsv_en; v.rsv_addr = rsv_addr; v.flush = flush;
        v.e1 = e1; v.e2 = e2; v.es = es; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic idle();
        i_wb_wr_reg_en = 0; i_wb_wr_reg_addr = 0; i_wb_wr_reg_data = 0;
        i_rs1_addr = 0; i_rs2_addr = 0; i_rs1_used = 0; i_rs2_used = 0;
        i_rsv_en = 0; i_rsv_addr = 0; i_flush = 0;
    endtask

    task automatic apply(input vec_t v);
        i_wb_wr_reg_en = v.wb_en; i_wb_wr_reg_addr = v.wb_addr; i_wb_wr_reg_data = v.wb_data;
        i_rs1_addr = v.rs1; i_rs1_used = v.u1; i_rs2_addr = v.rs2; i_rs2_used = v.u2;
        i_rsv_en = v.rsv_en; i_rsv_addr = v.rsv_addr; i_flush = v.flush;
    endtask

    task automatic check_outs(input string nm, input logic [31:0] e1, input logic [31:0] e2,
                              input logic es, input logic ee);
        chk({nm, ".rs1"},   o_rs1_data, e1);
        chk({nm, ".rs2"},   o_rs2_data, e2);
        chk({nm, ".stall"}, {31'd0, o_stall}, {31'd0, es});
        chk({nm, ".err"},   {31'd0, o_sb_err}, {31'd0, ee});
    endtask

    initial begin
        // ---------------- reset held with a write pending ----------------
        idle();
        rst_n = 1'b0;
        i_wb_wr_reg_en = 1; i_wb_wr_reg_addr = 5'd9; i_wb_wr_reg_data = 32'hAAAA_AAAA;
        i_rs1_addr = 5'd9; i_rs1_used = 1;
        #1;
        check_outs("reset_hold", 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        check_outs("reset_hold2", 32'h0, 32'h0, 1'b0, 1'b0);
        idle();
        rst_n = 1'b1;

        // ---------------- table-driven sequence ----------------
        //            name            wb a  data           rs1 u rs2 u  rsv a  fl  e1                       e2                      es            ee
        vecs.push_back(mk("x0_write",   1, 0, 32'd5,       0, 1, 0, 0, 0, 0, 0, 32'h0,                   32'h0,                  1'b0,         1'b0));
        vecs.push_back(mk("x0_read",    0, 0, 32'd0,       0, 1, 0, 0, 0, 0, 0, 32'h0,                   32'h0,                  1'b0,         1'b0));
        vecs.push_back(mk("raw_rsv",    0, 0, 32'd0,       0, 0, 0, 0, 1, 3, 0, 32'h0,                   32'h0,                  1'b0,         1'b0));
        vecs.push_back(mk("raw_stall",  0, 0, 32'd0,       3, 1, 0, 0, 0, 0, 0, 32'h0,                   32'h0,                  1'b1,         1'b0));
        vecs.push_back(mk("raw_wb",     1, 3, 32'hDEAD,    3, 1, 0, 0, 0, 0, 0, BYP ? 32'hDEAD : 32'h0,  32'h0,                  !BYP,         1'b0));
        vecs.push_back(mk("raw_after",  0, 0, 32'd0,       3, 1, 0, 0, 0, 0, 0, 32'hDEAD,                32'h0,                  1'b0,         1'b0));
        vecs.push_back(mk("sat_rsv1",   0, 0, 32'd0,       0, 0, 0, 0, 1, 7, 0, 32'h0,                   32'h0,                  1'b0,         1'b0));
        vecs.push_back(mk("sat_rsv2",   0, 0, 32'd0,       0, 0, 0, 0, 1, 7, 0, 32'h0,                   32'h0,                  1'b0,         1'b0));
        vecs.push_back(mk("sat_rsv3",   0, 0, 32'd0,       0, 0, 0, 0, 1, 7, 0, 32'h0,                   32'h0,                  1'b0,         1'b0));
        vecs.push_back(mk("sat_full",   0, 0, 32'd0,       0, 0, 0, 0, 1, 7, 0, 32'h0,                   32'h0,                  1'b1,         1'b0));
        vecs.push_back(mk("sat_wb",     1, 7, 32'h77,      7, 0, 0, 0, 1, 7, 0, 32'h0,                   32'h0,                  1'b1,         1'b0));
        vecs.push_back(mk("sat_rel",    0, 0, 32'd0,       7, 0, 0, 0, 1, 7, 0, 32'h77,                  32'h0,                  1'b0,         1'b0));
        vecs.push_back(mk("drain1",     1, 7, 32'h71,      7, 0, 0, 0, 0, 0, 0, 32'h77,                  32'h0,                  1'b0,         1'b0));
        vecs.push_back(mk("drain2",     1, 7, 32'h72,      7, 0, 0, 0, 0, 0, 0, 32'h71,                  32'h0,                  1'b0,         1'b0));
        vecs.push_back(mk("drain3",     1, 7, 32'h73,      7, 0, 0, 0, 0, 0, 0, BYP ? 32'h73 : 32'h72,   32'h0,                  1'b0,         1'b0));
        vecs.push_back(mk("drain_rd",   0, 0, 32'd0,       7, 1, 0, 0, 0, 0, 0, 32'h73,                  32'h0,                  1'b0,         1'b0));
        vecs.push_back(mk("sim_rsv",    0, 0, 32'd0,       0, 0, 0, 0, 1, 5, 0, 32'h0,                   32'h0,                  1'b0,         1'b0));
        vecs.push_back(mk("sim_both",   1, 5, 32'h55,      0, 0, 5, 0, 1, 5, 0, 32'h0,                   BYP ? 32'h55 : 32'h0,   1'b0,         1'b0));
        vecs.push_back(mk("sim_stall",  0, 0, 32'd0,       0, 0, 5, 1, 0, 0, 0, 32'h0,                   32'h55,                 1'b1,         1'b0));
        vecs.push_back(mk("sim_wb",     1, 5, 32'h56,      0, 0, 5, 1, 0, 0, 0, 32'h0,                   BYP ? 32'h56 : 32'h55,  !BYP,         1'b0));
        vecs.push_back(mk("sim_after",  0, 0, 32'd0,       0, 0, 5, 1, 0, 0, 0, 32'h0,                   32'h56,                 1'b0,         1'b0));
        vecs.push_back(mk("fl_rsv1",    0, 0, 32'd0,       0, 0, 0, 0, 1, 1, 0, 32'h0,                   32'h0,                  1'b0,         1'b0));
        vecs.push_back(mk("fl_rsv2",    0, 0, 32'd0,       0, 0, 0, 0, 1, 2, 0, 32'h0,                   32'h0,                  1'b0,         1'b0));
        vecs.push_back(mk("flush",      0, 0, 32'd0,       1, 1, 2, 1, 0, 0, 1, 32'h0,                   32'h0,                  1'b1,         1'b0));
        vecs.push_back(mk("fl_after",   0, 0, 32'd0,       1, 1, 2, 1, 0, 0, 0, 32'h0,                   32'h0,                  1'b0,         1'b0));
        vecs.push_back(mk("orphan_wb",  1, 1, 32'h11,      1, 1, 0, 0, 0, 0, 0, 32'h0,                   32'h0,                  1'b0,         1'b0));
        vecs.push_back(mk("err_set",    0, 0, 32'd0,       1, 1, 0, 0, 0, 0, 0, 32'h11,                  32'h0,                  1'b0,         1'b1));
        vecs.push_back(mk("fl_rsv_ovr", 0, 0, 32'd0,       0, 0, 0, 0, 1, 6, 1, 32'h0,                   32'h0,                  1'b0,         1'b1));
        vecs.push_back(mk("fl_rsv_chk", 0, 0, 32'd0,       6, 1, 0, 0, 0, 0, 0, 32'h0,                   32'h0,                  1'b0,         1'b1));
        vecs.push_back(mk("fl_dec_rsv", 0, 0, 32'd0,       0, 0, 0, 0, 1, 8, 0, 32'h0,                   32'h0,                  1'b0,         1'b1));
        vecs.push_back(mk("fl_dec_wb",  1, 8, 32'h88,      0, 0, 0, 0, 0, 0, 1, 32'h0,                   32'h0,                  1'b0,         1'b1));
        vecs.push_back(mk("fl_dec_chk", 0, 0, 32'd0,       8, 1, 3, 1, 0, 0, 0, 32'h88,                  32'hDEAD,               1'b0,         1'b1));

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            apply(vecs[k]);
            #1;
            check_outs(vecs[k].name, vecs[k].e1, vecs[k].e2, vecs[k].es, vecs[k].ee);
        end

        // ---------------- reset during a pending write ----------------
        @(negedge clk);
        idle();
        i_rsv_en = 1; i_rsv_addr = 5'd9;
        @(negedge clk);
        idle();
        i_wb_wr_reg_en = 1; i_wb_wr_reg_addr = 5'd9; i_wb_wr_reg_data = 32'h5555_5555;
        i_rs1_addr = 5'd9; i_rs1_used = 1;
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("rst_mid", 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        i_rs1_addr = 5'd9; i_rs1_used = 1;
        i_rs2_addr = 5'd3; i_rs2_used = 1;
        #1;
        check_outs("rst_after", 32'h0, 32'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_rf_scoreboard
`default_nettype wire
